periph_bus_master: RTL and testbench

//  Initiator side of the peripheral register bus. Turns single CPU load/store requests into

---
 rtl/periph_bus_master_pkg.sv | 19 +
 rtl/periph_bus_master_addr_decode.sv | 23 ++
 rtl/periph_bus_master.sv | 179 +++++++++++++++++
 tb/tb_periph_bus_master.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_bus_master_pkg.sv
// rtl/periph_bus_master_pkg.sv - shared constants and FSM encoding for the peripheral bus master
package periph_bus_master_pkg;

  localparam int PERIPH_DATA_WIDTH    = 32;
  localparam int PERIPH_ADDR_WIDTH    = 8;
  localparam int PERIPH_DEV_SEL_WIDTH = 2;
  localparam int PBM_TIMEOUT_CYCLES   = 16;

  // Returned on reads that never reached a slave; sliced down to the bus width.
  localparam logic [63:0] PBM_ERR_PATTERN = '1;

  typedef enum logic [1:0] {
    PBM_IDLE   = 2'd0,
    PBM_SETUP  = 2'd1,
    PBM_STROBE = 2'd2,
    PBM_DONE   = 2'd3
  } pbm_state_t;

endpackage

// File: rtl/periph_bus_master_addr_decode.sv
// rtl/periph_bus_master_addr_decode.sv - device index to one-hot chip select plus validity flag
module periph_addr_decode
  import periph_bus_master_pkg::*;
#(
  parameter int DEV_SEL_WIDTH = PERIPH_DEV_SEL_WIDTH,
  parameter int N_DEVICES     = 4
) (
  input  logic [DEV_SEL_WIDTH-1:0] dev_idx,
  output logic [N_DEVICES-1:0]     cs,
  output logic                     dev_valid
);

  always_comb begin
    cs = '0;
    for (int i = 0; i < N_DEVICES; i++) begin
      cs[i] = (dev_idx == DEV_SEL_WIDTH'(i));
    end
  end

  // One extra bit so N_DEVICES == 2**DEV_SEL_WIDTH still compares correctly.
  assign dev_valid = ({1'b0, dev_idx} < (DEV_SEL_WIDTH + 1)'(N_DEVICES));

endmodule

// File: rtl/periph_bus_master.sv
// rtl/periph_bus_master.sv - CPU to peripheral register bus initiator (timeout via PERIPH_MASTER_TIMEOUT_EN)
module periph_bus_master
  import periph_bus_master_pkg::*;
#(
  parameter int DATA_WIDTH     = PERIPH_DATA_WIDTH,
  parameter int ADDR_WIDTH     = PERIPH_ADDR_WIDTH,
  parameter int DEV_SEL_WIDTH  = PERIPH_DEV_SEL_WIDTH,
  parameter int N_DEVICES      = 4,
  parameter int TIMEOUT_CYCLES = PBM_TIMEOUT_CYCLES
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cpu_req,
  input  logic                            cpu_we,
  input  logic [DEV_SEL_WIDTH+ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]           cpu_wdata,
  output logic [DATA_WIDTH-1:0]           cpu_rdata,
  output logic                            cpu_ack,
  output logic                            cpu_err,
  output logic                            busy,
  output logic [N_DEVICES-1:0]            periph_cs,
  output logic [ADDR_WIDTH-1:0]           periph_addr,
  inout  wire  [DATA_WIDTH-1:0]           periph_data,
  output logic                            periph_read,
  output logic                            periph_write,
  input  logic                            periph_ready
);

  localparam logic [DATA_WIDTH-1:0] ERR_RDATA = PBM_ERR_PATTERN[DATA_WIDTH-1:0];

  pbm_state_t state_q, next_state;

  logic [N_DEVICES-1:0]  cs_q, cs_d, dec_cs;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic                  we_q, we_d;
  logic                  read_q, read_d, write_q, write_d;
  logic                  drive_q, drive_d;
  logic                  ack_q, ack_d, err_q, err_d;
  logic                  dev_valid;

`ifdef PERIPH_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  periph_addr_decode #(
    .DEV_SEL_WIDTH (DEV_SEL_WIDTH),
    .N_DEVICES     (N_DEVICES)
  ) u_decode (
    .dev_idx   (cpu_addr[ADDR_WIDTH +: DEV_SEL_WIDTH]),
    .cs        (dec_cs),
    .dev_valid (dev_valid)
  );

  // All outputs are computed for the state being entered and registered with it.
  always_comb begin
    next_state = state_q;
    cs_d       = cs_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    rdata_d    = rdata_q;
    read_d     = 1'b0;
    write_d    = 1'b0;
    drive_d    = 1'b0;
    ack_d      = 1'b0;
    err_d      = 1'b0;
`ifdef PERIPH_MASTER_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
`endif
    unique case (state_q)
      PBM_IDLE: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          wdata_d = cpu_wdata;
          if (dev_valid) begin
            next_state = PBM_SETUP;
            cs_d       = dec_cs;
            addr_d     = cpu_addr[ADDR_WIDTH-1:0];
            drive_d    = cpu_we;
          end else begin
            next_state = PBM_DONE;
            ack_d      = 1'b1;
            err_d      = 1'b1;
            if (!cpu_we) rdata_d = ERR_RDATA;
          end
        end
      end
      PBM_SETUP: begin
        next_state = PBM_STROBE;
        read_d     = !we_q;
        write_d    = we_q;
        drive_d    = we_q;
`ifdef PERIPH_MASTER_TIMEOUT_EN
        tmo_cnt_d  = '0;
`endif
      end
      PBM_STROBE: begin
        read_d  = read_q;
        write_d = write_q;
        drive_d = drive_q;
        if (periph_ready) begin
          next_state = PBM_DONE;
          ack_d      = 1'b1;
          cs_d       = '0;
          read_d     = 1'b0;
          write_d    = 1'b0;
          drive_d    = 1'b0;
          if (!we_q) rdata_d = periph_data;
        end
`ifdef PERIPH_MASTER_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          next_state = PBM_DONE;
          ack_d      = 1'b1;
          err_d      = 1'b1;
          cs_d       = '0;
          read_d     = 1'b0;
          write_d    = 1'b0;
          drive_d    = 1'b0;
          rdata_d    = ERR_RDATA;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      PBM_DONE: begin
        next_state = PBM_IDLE;
        cs_d       = '0;
      end
      default: next_state = PBM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PBM_IDLE;
      cs_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      rdata_q   <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      drive_q   <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
`ifdef PERIPH_MASTER_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      state_q   <= next_state;
      cs_q      <= cs_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      rdata_q   <= rdata_d;
      read_q    <= read_d;
      write_q   <= write_d;
      drive_q   <= drive_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
`ifdef PERIPH_MASTER_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
`endif
    end
  end

  assign periph_data  = drive_q ? wdata_q : 'z;
  assign periph_cs    = cs_q;
  assign periph_addr  = addr_q;
  assign periph_read  = read_q;
  assign periph_write = write_q;
  assign cpu_rdata    = rdata_q;
  assign cpu_ack      = ack_q;
  assign cpu_err      = err_q;
  assign busy         = (state_q != PBM_IDLE);

endmodule

// File: tb/tb_periph_bus_master.sv
// tb/tb_periph_bus_master.sv - scoreboard bench for periph_bus_master with a behavioural slave
module tb_periph_bus_master;

  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int DSW = 2;
  localparam int ND  = 3;
  localparam int TMO = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req;
  logic              cpu_we;
  logic [DSW+AW-1:0] cpu_addr;
  logic [DW-1:0]     cpu_wdata;
  logic [DW-1:0]     cpu_rdata;
  logic              cpu_ack;
  logic              cpu_err;
  logic              busy;
  logic [ND-1:0]     periph_cs;
  logic [AW-1:0]     periph_addr;
  wire  [DW-1:0]     periph_data;
  logic              periph_read;
  logic              periph_write;
  logic              periph_ready;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          lat;
    logic        err;
    logic        chk_rdata;
    logic [DW-1:0] rdata;
  } exp_t;
  exp_t sb[$];

  periph_bus_master #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .DEV_SEL_WIDTH  (DSW),
    .N_DEVICES      (ND),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_ack      (cpu_ack),
    .cpu_err      (cpu_err),
    .busy         (busy),
    .periph_cs    (periph_cs),
    .periph_addr  (periph_addr),
    .periph_data  (periph_data),
    .periph_read  (periph_read),
    .periph_write (periph_write),
    .periph_ready (periph_ready)
  );

  always #5 clk = ~clk;

  // Behavioural slave: register file, programmable ready delay, drives only during read strobe.
  logic [DW-1:0] mem [0:1023];
  int            strobe_cnt  = 0;
  int            ready_delay = 0;
  logic          keeper_en   = 1'b1;
  logic [1:0]    sdev;

  always_comb sdev = periph_cs[2] ? 2'd2 : (periph_cs[1] ? 2'd1 : 2'd0);
  assign periph_ready = (periph_read || periph_write) && (strobe_cnt >= ready_delay);

  always @(posedge clk) begin
    if (periph_read || periph_write) strobe_cnt <= strobe_cnt + 1;
    else strobe_cnt <= 0;
    if (periph_write && periph_ready) mem[{sdev, periph_addr}] <= periph_data;
  end

  // Keeper pulls the bus to zero whenever nobody should be driving it.
  assign periph_data = periph_read ? mem[{sdev, periph_addr}] : 'z;
  assign periph_data = (keeper_en && !periph_read) ? '0 : 'z;

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_access(input logic we, input logic [DSW-1:0] dev, input logic [AW-1:0] ra,
                            input logic [DW-1:0] wd, input int max_cyc, output int lat,
                            output logic err, output logic [DW-1:0] rd, output int strobe_cyc,
                            output int cs_cyc, output int bus_bad);
    keeper_en  = !we;
    cpu_we     = we;
    cpu_addr   = {dev, ra};
    cpu_wdata  = wd;
    cpu_req    = 1'b1;
    lat        = -1;
    err        = 1'b0;
    rd         = '0;
    strobe_cyc = 0;
    cs_cyc     = 0;
    bus_bad    = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      cycle();
      if (periph_read || periph_write) strobe_cyc++;
      if (periph_cs != '0) cs_cyc++;
      if (!we && !periph_read && periph_data !== '0) bus_bad++;
      if (cpu_ack) begin
        lat = i;
        err = cpu_err;
        rd  = cpu_rdata;
        break;
      end
    end
    cpu_req   = 1'b0;
    keeper_en = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) cycle();
    n_checks++;
    if ({cpu_ack, cpu_err, busy, periph_read, periph_write} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {cpu_ack, cpu_err, busy, periph_read, periph_write});
    end
    n_checks++;
    if (periph_cs !== '0 || periph_addr !== '0 || cpu_rdata !== '0) begin
      n_fail++; $display("FAIL reset_bus: cs=%b addr=%h rdata=%h want 0", periph_cs, periph_addr, cpu_rdata);
    end
    n_checks++;
    if (periph_data !== '0) begin
      n_fail++; $display("FAIL reset_data_released: got %h want 0 (keeper only)", periph_data);
    end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_write();
    logic [DW-1:0] wd = 32'h8000_000A;
    exp_t e;
    sb.push_back('{lat: 3, err: 1'b0, chk_rdata: 1'b0, rdata: '0});
    keeper_en = 1'b0;
    cpu_we = 1'b1; cpu_addr = {2'd1, 8'd3}; cpu_wdata = wd; cpu_req = 1'b1;
    cycle();
    n_checks++;
    if (periph_cs !== 3'b010 || periph_addr !== 8'd3 || periph_write !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL wr_setup: cs=%b addr=%h wr=%b busy=%b want 010 03 0 1", periph_cs, periph_addr, periph_write, busy);
    end
    n_checks++;
    if (periph_data !== wd) begin
      n_fail++; $display("FAIL wr_setup_data: got %h want %h", periph_data, wd);
    end
    cycle();
    n_checks++;
    if (periph_write !== 1'b1 || periph_read !== 1'b0 || periph_cs !== 3'b010 || periph_data !== wd) begin
      n_fail++; $display("FAIL wr_strobe: wr=%b rd=%b cs=%b data=%h want 1 0 010 %h", periph_write, periph_read, periph_cs, periph_data, wd);
    end
    cycle();
    e = sb.pop_front();
    n_checks++;
    if (cpu_ack !== 1'b1 || cpu_err !== e.err) begin
      n_fail++; $display("FAIL wr_ack: ack=%b err=%b want 1 %b at lat %0d", cpu_ack, cpu_err, e.err, e.lat);
    end
    cpu_req = 1'b0;
    keeper_en = 1'b1;
    #1;
    n_checks++;
    if (periph_data !== '0 || periph_cs !== '0 || periph_write !== 1'b0) begin
      n_fail++; $display("FAIL wr_done_release: data=%h cs=%b wr=%b want 0 0 0", periph_data, periph_cs, periph_write);
    end
    cycle();
    n_checks++;
    if (cpu_ack !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL wr_ack_pulse: ack=%b busy=%b want 0 0", cpu_ack, busy);
    end
  endtask

  task automatic test_read(input int delay, input string tag);
    int lat, sc, cc, bb;
    logic err;
    logic [DW-1:0] rd;
    exp_t e;
    ready_delay = delay;
    sb.push_back('{lat: 3 + delay, err: 1'b0, chk_rdata: 1'b1, rdata: 32'h8000_000A});
    run_access(1'b0, 2'd1, 8'd3, '0, 40, lat, err, rd, sc, cc, bb);
    e = sb.pop_front();
    n_checks++;
    if (lat !== e.lat || err !== e.err) begin
      n_fail++; $display("FAIL %s_latency: lat=%0d err=%b want %0d %b", tag, lat, err, e.lat, e.err);
    end
    n_checks++;
    if (e.chk_rdata && rd !== e.rdata) begin
      n_fail++; $display("FAIL %s_rdata: got %h want %h", tag, rd, e.rdata);
    end
    n_checks++;
    if (bb != 0 || sc != 1 + delay) begin
      n_fail++; $display("FAIL %s_bus: driven_cycles=%0d strobe_cycles=%0d want 0 %0d", tag, bb, sc, 1 + delay);
    end
    ready_delay = 0;
    cycle();
  endtask

  task automatic test_bad_device();
    int lat, sc, cc, bb;
    logic err;
    logic [DW-1:0] rd;
    exp_t e;
    sb.push_back('{lat: 1, err: 1'b1, chk_rdata: 1'b1, rdata: '1});
    run_access(1'b0, 2'd3, 8'd7, '0, 10, lat, err, rd, sc, cc, bb);
    e = sb.pop_front();
    n_checks++;
    if (lat !== e.lat || err !== e.err || rd !== e.rdata) begin
      n_fail++; $display("FAIL bad_dev_read: lat=%0d err=%b rdata=%h want %0d %b %h", lat, err, rd, e.lat, e.err, e.rdata);
    end
    n_checks++;
    if (sc != 0 || cc != 0) begin
      n_fail++; $display("FAIL bad_dev_read_bus: strobes=%0d cs=%0d want 0 0", sc, cc);
    end
    cycle();
    sb.push_back('{lat: 1, err: 1'b1, chk_rdata: 1'b0, rdata: '0});
    run_access(1'b1, 2'd3, 8'd7, 32'h5555_AAAA, 10, lat, err, rd, sc, cc, bb);
    e = sb.pop_front();
    n_checks++;
    if (lat !== e.lat || err !== e.err || sc != 0 || cc != 0) begin
      n_fail++; $display("FAIL bad_dev_write: lat=%0d err=%b strobes=%0d cs=%0d want %0d %b 0 0", lat, err, sc, cc, e.lat, e.err);
    end
    cycle();
  endtask

  task automatic test_back_to_back();
    int lat, sc, cc, bb;
    logic err;
    logic [DW-1:0] rd;
    exp_t e;
    logic [DW-1:0] vals [3] = '{32'h0000_0011, 32'hDEAD_BEEF, 32'hFFFF_0000};
    // Request held straight through each ack: every ack lands 4 cycles after the previous one.
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{lat: (i == 0) ? 3 : 4, err: 1'b0, chk_rdata: 1'b0, rdata: '0});
      run_access(1'b1, 2'(i), 8'(16 + i), vals[i], 20, lat, err, rd, sc, cc, bb);
      e = sb.pop_front();
      n_checks++;
      if (lat !== e.lat || err !== e.err) begin
        n_fail++; $display("FAIL b2b_write%0d: lat=%0d err=%b want %0d %b", i, lat, err, e.lat, e.err);
      end
      cpu_req = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{lat: 4, err: 1'b0, chk_rdata: 1'b1, rdata: vals[i]});
    end
    for (int i = 0; i < 3; i++) begin
      run_access(1'b0, 2'(i), 8'(16 + i), '0, 20, lat, err, rd, sc, cc, bb);
      e = sb.pop_front();
      n_checks++;
      if (lat !== e.lat || err !== e.err || rd !== e.rdata) begin
        n_fail++; $display("FAIL b2b_read%0d: lat=%0d err=%b rdata=%h want %0d %b %h", i, lat, err, rd, e.lat, e.err, e.rdata);
      end
      if (i < 2) cpu_req = 1'b1;
    end
    cycle();
  endtask

  task automatic test_timeout();
    int lat, sc, cc, bb;
    logic err;
    logic [DW-1:0] rd;
`ifdef PERIPH_MASTER_TIMEOUT_EN
    exp_t e;
    ready_delay = 1000;
    sb.push_back('{lat: 2 + TMO, err: 1'b1, chk_rdata: 1'b1, rdata: '1});
    run_access(1'b0, 2'd1, 8'd3, '0, 60, lat, err, rd, sc, cc, bb);
    e = sb.pop_front();
    n_checks++;
    if (lat !== e.lat || err !== e.err || rd !== e.rdata) begin
      n_fail++; $display("FAIL timeout: lat=%0d err=%b rdata=%h want %0d %b %h", lat, err, rd, e.lat, e.err, e.rdata);
    end
    cycle();
    ready_delay = TMO - 1;
    sb.push_back('{lat: 2 + TMO, err: 1'b0, chk_rdata: 1'b1, rdata: 32'h8000_000A});
    run_access(1'b0, 2'd1, 8'd3, '0, 60, lat, err, rd, sc, cc, bb);
    e = sb.pop_front();
    n_checks++;
    if (lat !== e.lat || err !== e.err || rd !== e.rdata) begin
      n_fail++; $display("FAIL timeout_ready_wins: lat=%0d err=%b rdata=%h want %0d %b %h", lat, err, rd, e.lat, e.err, e.rdata);
    end
    ready_delay = 0;
    cycle();
`else
    ready_delay = 1000;
    run_access(1'b0, 2'd1, 8'd3, '0, 40, lat, err, rd, sc, cc, bb);
    n_checks++;
    if (lat != -1 || busy !== 1'b1 || periph_read !== 1'b1) begin
      n_fail++; $display("FAIL no_timeout_wait: lat=%0d busy=%b rd=%b want -1 1 1", lat, busy, periph_read);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    ready_delay = 0;
    cycle();
`endif
  endtask

  task automatic test_reset_mid_access();
    int lat, sc, cc, bb;
    logic err;
    logic [DW-1:0] rd;
    exp_t e;
    int acks = 0;
    ready_delay = 1000;
    cpu_we = 1'b0; cpu_addr = {2'd0, 8'd5}; cpu_req = 1'b1;
    cycle();
    cycle();
    n_checks++;
    if (periph_read !== 1'b1) begin
      n_fail++; $display("FAIL mid_rst_in_strobe: rd=%b want 1", periph_read);
    end
    rst = 1'b1;
    cpu_req = 1'b0;
    cycle();
    n_checks++;
    if (periph_read !== 1'b0 || periph_write !== 1'b0 || periph_cs !== '0 || cpu_ack !== 1'b0 || busy !== 1'b0 || periph_data !== '0) begin
      n_fail++; $display("FAIL mid_rst_abort: rd=%b wr=%b cs=%b ack=%b busy=%b data=%h want all 0", periph_read, periph_write, periph_cs, cpu_ack, busy, periph_data);
    end
    rst = 1'b0;
    ready_delay = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (cpu_ack) acks++;
    end
    n_checks++;
    if (acks != 0 || cpu_rdata !== '0) begin
      n_fail++; $display("FAIL mid_rst_no_ack: acks=%0d rdata=%h want 0 0", acks, cpu_rdata);
    end
    sb.push_back('{lat: 3, err: 1'b0, chk_rdata: 1'b0, rdata: '0});
    run_access(1'b1, 2'd0, 8'd5, 32'h1234_5678, 20, lat, err, rd, sc, cc, bb);
    e = sb.pop_front();
    n_checks++;
    if (lat !== e.lat || err !== e.err) begin
      n_fail++; $display("FAIL mid_rst_recover_wr: lat=%0d err=%b want %0d %b", lat, err, e.lat, e.err);
    end
    cycle();
    sb.push_back('{lat: 3, err: 1'b0, chk_rdata: 1'b1, rdata: 32'h1234_5678});
    run_access(1'b0, 2'd0, 8'd5, '0, 20, lat, err, rd, sc, cc, bb);
    e = sb.pop_front();
    n_checks++;
    if (lat !== e.lat || err !== e.err || rd !== e.rdata) begin
      n_fail++; $display("FAIL mid_rst_recover_rd: lat=%0d err=%b rdata=%h want %0d %b %h", lat, err, rd, e.lat, e.err, e.rdata);
    end
    cycle();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read(0, "read");
    test_read(5, "read_delay5");
    test_bad_device();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d entries left want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
